// File: rtl/disparity_interp.sv
// disparity_interp: sub-pixel disparity via pipelined restoring divider with backpressure, saturation and per-line not-found count
module disparity_interp #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 7,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_last,
  input  logic                         s_not_found,
  input  logic signed [DATA_WIDTH-1:0] s_x0,
  input  logic signed [DATA_WIDTH-1:0] s_pos,
  input  logic signed [DATA_WIDTH-1:0] s_y_sub_y0,
  input  logic signed [DATA_WIDTH-1:0] s_y_sub_y1,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic signed [DATA_WIDTH-1:0] m_disparity,
  output logic [2:0]                   m_status,
  output logic [CNT_WIDTH-1:0]         nf_cnt,
  output logic                         nf_cnt_vld
);
  localparam int DW = DATA_WIDTH;
  localparam int F = FRAC_BITS;
  localparam int RW = DW + 2;
  localparam int SW = DW + F + 2;
  localparam int N = F + 2;
  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  logic en;
  logic v [N];
  logic lst [N];
  logic nf [N];
  logic cl [N];
  logic mx [N];
  logic signed [DW:0] base [N];
  logic [RW-1:0] rem [N];
  logic [RW-1:0] dm [N];
  logic [F:0] q [N];
  logic [RW-1:0] rin [F+1];
  logic [RW-1:0] rnx [F+1];
  logic ge [F+1];
  logic signed [DW:0] n0, d0;
  logic [DW:0] nm0, dm0;
  logic z0, mx0;
  logic [F:0] qf;
  logic signed [SW-1:0] rs;
  logic hi, lo, hs;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  assign en = ~m_valid | m_ready;
  assign s_ready = en;
  // Input stage: signed numerator/denominator, their magnitudes and the clamp decision
  always_comb begin
    n0 = {s_y_sub_y0[DW-1], s_y_sub_y0};
    d0 = n0 - {s_y_sub_y1[DW-1], s_y_sub_y1};
    nm0 = n0[DW] ? -n0 : n0;
    dm0 = d0[DW] ? -d0 : d0;
    z0 = (d0 == 0) || (n0 != 0 && n0[DW] != d0[DW]);
    mx0 = !z0 && nm0 > dm0;
  end
  // One restoring step per stage; the first step compares unshifted so |num|==|den| yields 2^F
  always_comb begin
    for (int k = 0; k <= F; k++) begin
      rin[k] = k == 0 ? rem[0] : rem[k] << 1;
      ge[k] = rin[k] >= dm[k];
      rnx[k] = ge[k] ? rin[k] - dm[k] : rin[k];
    end
  end
  // Final stage: pick forced or divided fraction, add to the scaled integer part, detect overflow
  always_comb begin
    qf = mx[N-1] ? {1'b1, {F{1'b0}}} : cl[N-1] ? '0 : q[N-1];
    rs = (SW'(base[N-1]) <<< F) + SW'(qf);
    hi = rs > MAXV;
    lo = rs < MINV;
  end
  // Whole pipeline advances in lockstep on the global enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        v[k] <= 1'b0;
        lst[k] <= 1'b0;
        nf[k] <= 1'b0;
        cl[k] <= 1'b0;
        mx[k] <= 1'b0;
        base[k] <= '0;
        rem[k] <= '0;
        dm[k] <= '0;
        q[k] <= '0;
      end
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_disparity <= '0;
      m_status <= '0;
    end else if (en) begin
      v[0] <= s_valid;
      lst[0] <= s_last;
      nf[0] <= s_not_found;
      cl[0] <= z0 | mx0;
      mx[0] <= mx0;
      base[0] <= {s_x0[DW-1], s_x0} - {s_pos[DW-1], s_pos};
      rem[0] <= RW'(nm0);
      dm[0] <= RW'(dm0);
      q[0] <= '0;
      for (int k = 0; k <= F; k++) begin
        v[k+1] <= v[k];
        lst[k+1] <= lst[k];
        nf[k+1] <= nf[k];
        cl[k+1] <= cl[k];
        mx[k+1] <= mx[k];
        base[k+1] <= base[k];
        rem[k+1] <= rnx[k];
        dm[k+1] <= dm[k];
        q[k+1] <= q[k] | ((F+1)'(ge[k]) << (F - k));
      end
      m_valid <= v[N-1];
      m_last <= lst[N-1];
      m_disparity <= nf[N-1] ? '0 : hi ? MAXV[DW-1:0] : lo ? MINV[DW-1:0] : rs[DW-1:0];
      m_status <= nf[N-1] ? 3'b001 : {hi | lo, cl[N-1], 1'b0};
    end
  end
  assign hs = m_valid & m_ready;
  assign cnt_nx = (m_status[0] && cnt != '1) ? cnt + 1'b1 : cnt;
  // Not-found line counter, updated only on output handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      nf_cnt <= '0;
      nf_cnt_vld <= 1'b0;
    end else begin
      cnt <= hs ? (m_last ? '0 : cnt_nx) : cnt;
      nf_cnt <= (hs && m_last) ? cnt_nx : nf_cnt;
      nf_cnt_vld <= hs && m_last;
    end
  end
endmodule

// File: tb/tb_disparity_interp.sv
// tb_disparity_interp: directed vectors, backpressured stream and line-count checks for disparity_interp
module tb_disparity_interp;
  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, s_last, s_not_found;
  logic signed [15:0] s_x0, s_pos, s_y_sub_y0, s_y_sub_y1;
  logic m_valid, m_ready, m_last;
  logic signed [15:0] m_disparity;
  logic [2:0] m_status;
  logic [15:0] nf_cnt;
  logic nf_cnt_vld;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string name;
    int x0, pos, y0, y1;
    bit nf;
    int d, st;
  } vec_t;
  vec_t tv [15];
  int exp_d [$];
  int exp_s [$];
  bit exp_l [$];
  int stream_nf;

  disparity_interp dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_not_found(s_not_found), .s_x0(s_x0), .s_pos(s_pos), .s_y_sub_y0(s_y_sub_y0),
    .s_y_sub_y1(s_y_sub_y1), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_disparity(m_disparity), .m_status(m_status), .nf_cnt(nf_cnt), .nf_cnt_vld(nf_cnt_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic void model(input int x0, pos, y0, y1, input bit nf, output int d, output int st);
    int den, an, ad, q, c, r, s;
    if (nf) begin
      d = 0;
      st = 1;
      return;
    end
    den = y0 - y1;
    an = y0 < 0 ? -y0 : y0;
    ad = den < 0 ? -den : den;
    if (den == 0 || (y0 != 0 && ((y0 < 0) != (den < 0)))) begin q = 0; c = 1; end
    else if (an > ad) begin q = 128; c = 1; end
    else begin q = an * 128 / ad; c = 0; end
    r = (x0 - pos) * 128 + q;
    s = 1;
    if (r > 32767) d = 32767;
    else if (r < -32768) d = -32768;
    else begin d = r; s = 0; end
    st = (s << 2) | (c << 1);
  endfunction

  task automatic send_beat(input int x0, pos, y0, y1, input bit nf, input bit last);
    int n = 0;
    bit hs = 0;
    s_x0 = 16'(x0);
    s_pos = 16'(pos);
    s_y_sub_y0 = 16'(y0);
    s_y_sub_y1 = 16'(y1);
    s_not_found = nf;
    s_last = last;
    s_valid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!hs) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_line(input string nm, input int exp);
    bit seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_last) seen = 1;
    end
    chk({nm, "_last_seen"}, seen, 1);
    if (seen) begin
      chk({nm, "_vld_early"}, nf_cnt_vld, 0);
      @(negedge clk);
      chk({nm, "_vld_pulse"}, nf_cnt_vld, 1);
      chk({nm, "_nf_cnt"}, nf_cnt, exp);
      @(negedge clk);
      chk({nm, "_vld_drop"}, nf_cnt_vld, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, got, seenv;
    tv[0]  = '{"basic",    100,  40,  30, -90, 0,   7712, 0};
    tv[1]  = '{"den_zero", 100,  40,   0,   0, 0,   7680, 2};
    tv[2]  = '{"over",     100,  40,  50,  10, 0,   7808, 2};
    tv[3]  = '{"sat_pos",  300,   0,   0,  -1, 0,  32767, 4};
    tv[4]  = '{"sat_neg", -300,   0,   0,  -1, 0, -32768, 4};
    tv[5]  = '{"nf",       100,  40,  30, -90, 1,      0, 1};
    tv[6]  = '{"neg_den",  100,  40, -30,  90, 0,   7712, 0};
    tv[7]  = '{"sign_mis", 100,  40,  30,  60, 0,   7680, 2};
    tv[8]  = '{"equal",     10,  20,  20,   0, 0,  -1152, 0};
    tv[9]  = '{"third",      0,   0,   1,  -2, 0,     42, 0};
    tv[10] = '{"edge_max", 255,   0, 127,   0, 0,  32767, 4};
    tv[11] = '{"edge_in",  255,   0,   1,  -2, 0,  32682, 0};
    tv[12] = '{"edge_min",-256,   0,   0,  -1, 0, -32768, 0};
    tv[13] = '{"num_zero",   5,   5,   0,   7, 0,      0, 0};
    tv[14] = '{"nf_sat",   300,   0,   0,  -1, 1,      0, 1};
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_not_found = 1'b0;
    s_x0 = '0;
    s_pos = '0;
    s_y_sub_y0 = '0;
    s_y_sub_y1 = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_disp", m_disparity, 0);
    chk("rst_m_status", m_status, 0);
    chk("rst_nf_cnt", nf_cnt, 0);
    chk("rst_nf_vld", nf_cnt_vld, 0);
    chk("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      send_beat(tv[i].x0, tv[i].pos, tv[i].y0, tv[i].y1, tv[i].nf, 1'b0);
      cyc = 1;
      while (!m_valid && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      if (i == 0) chk("latency", cyc, 10);
      chk({tv[i].name, "_valid"}, m_valid, 1);
      chk({tv[i].name, "_disp"}, int'(m_disparity), tv[i].d);
      chk({tv[i].name, "_status"}, m_status, tv[i].st);
    end
    do_reset();
    stream_nf = 0;
    got = 0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          int x0, pos, y0, y1, d, st;
          bit nf;
          x0 = int'($urandom_range(600)) - 300;
          pos = int'($urandom_range(100)) - 50;
          y0 = int'($urandom_range(200)) - 100;
          y1 = int'($urandom_range(200)) - 100;
          nf = $urandom_range(7) == 0;
          stream_nf += int'(nf);
          model(x0, pos, y0, y1, nf, d, st);
          exp_d.push_back(d);
          exp_s.push_back(st);
          exp_l.push_back(i == 63);
          send_beat(x0, pos, y0, y1, nf, i == 63);
        end
      end
      begin
        cyc = 0;
        while (got < 64 && cyc < 3000) begin
          @(posedge clk);
          #1;
          m_ready = (cyc >= 5 && cyc <= 9) ? 1'b0 : (cyc < 5 ? 1'b1 : 1'($urandom_range(1)));
          @(negedge clk);
          if (m_valid && m_ready) begin
            chk("stream_disp", int'(m_disparity), exp_d.pop_front());
            chk("stream_status", m_status, exp_s.pop_front());
            chk("stream_last", m_last, exp_l.pop_front());
            got++;
          end
          cyc++;
        end
        chk("stream_count", got, 64);
        @(negedge clk);
        chk("stream_nf_vld", nf_cnt_vld, 1);
        chk("stream_nf_cnt", nf_cnt, stream_nf);
      end
    join
    do_reset();
    for (int i = 0; i < 8; i++) send_beat(50 + i, 10, 30, -90, i == 1 || i == 3 || i == 6, i == 7);
    wait_line("line1", 3);
    for (int i = 0; i < 3; i++) send_beat(20, 0, 10, -10, 1'b1, 1'b0);
    seenv = 0;
    for (int n = 0; n < 40 && seenv == 0; n++) begin
      @(negedge clk);
      if (m_valid) seenv = 1;
    end
    chk("pre_rst_valid", seenv, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_status", m_status, 0);
    chk("midrst_nf_cnt", nf_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seenv = 0;
    repeat (15) begin
      @(negedge clk);
      if (m_valid) seenv++;
    end
    chk("no_partial", seenv, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_beat(-20, 5, 40, 0, i == 0 || i == 2, i == 3);
    wait_line("line2", 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
